tone_synth: RTL and testbench
=============================

TONE_SYNTH -- requirements
Module: tone_synth

Interface
REQ-001 The block SHALL have parameter NVOICE, default 1, number of voices (legal range 1..4).
REQ-002 The block SHALL have parameter PERIOD_W, default 7, phase counter and period width.
REQ-003 The block SHALL have parameter SAMPLE_W, default 24, output sample width.
REQ-004 The block SHALL have a single clock and synchronous active-high reset, as follows:
- clk100  in  1  100 MHz system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- new_sample  in  1  one-cycle codec sample strobe.
- enable  in  1  run gate; low behaves as reset except for the pipeline valid.
- period  in  NVOICE*PERIOD_W  per-voice period in samples; voice v is at bits [v*PERIOD_W +: PERIOD_W]; 0 means silent.
- mode  in  NVOICE*2  per-voice waveform select.
- pan  in  NVOICE*2  per-voice routing; bit0 = left, bit1 = right.
- audio_l  out  SAMPLE_W  left sample.
- audio_r  out  SAMPLE_W  right sample.
- sample_valid  out  1  one-cycle pulse qualifying audio_l/audio_r.

Function
REQ-005 Each voice SHALL hold an unsigned phase counter ph of PERIOD_W bits.
REQ-006 On new_sample with enable high, ph SHALL go to 0 when ph >= period-1, and SHALL otherwise increment by 1.
- The >= compare makes a period lowered mid-run wrap on the next sample.
REQ-007 A voice with period 0 SHALL hold ph at 0 and SHALL contribute 0.
REQ-008 Waveform value w (PERIOD_W bits) SHALL be computed from the pre-update ph as follows:
- mode 0 saw: w = ph.
- mode 1 square: w = all-ones if ph < (period>>1), else 0.
- mode 2 triangle: w = 2*ph if ph < (period>>1), else 2*(period-1-ph); saturate at all-ones.
- mode 3: w = 0.
REQ-009 The mix SHALL be the unsigned sum of w over the routed voices, of width MIX_W = PERIOD_W + clog2(NVOICE), with no overflow possible.
REQ-010 The output SHALL be audio = mix << (SAMPLE_W - MIX_W), zero-filled in the LSBs.
REQ-011 sample_valid SHALL assert exactly one cycle after each new_sample that arrives with enable high.
- audio_l/audio_r SHALL carry that sample's value in the same cycle.
- Outside a sample_valid cycle, audio_l/audio_r SHALL be 0.
REQ-012 new_sample arriving on consecutive cycles SHALL each produce a sample; no strobe SHALL be dropped.
REQ-013 enable low SHALL clear all ph to 0 and suppress sample_valid.
- A sample_valid already registered from the prior cycle SHALL still be emitted.
REQ-014 Changes to period, mode or pan SHALL take effect at the next new_sample, with no glitch state.

Reset
REQ-015 rst high SHALL clear all ph, audio_l, audio_r and sample_valid to 0 in the next cycle.
REQ-016 rst SHALL override enable and new_sample.
REQ-017 rst asserted mid-sample SHALL drop the pending sample_valid.

Configuration
REQ-018 With TONE_SYNTH_PAN_EN defined, routing SHALL follow pan per channel:
- the left mix SHALL sum voices with pan bit0 set;
- the right mix SHALL sum voices with pan bit1 set.
REQ-019 Without TONE_SYNTH_PAN_EN, pan SHALL be ignored and audio_r SHALL equal audio_l, with all voices routed to both channels.
- The pan port SHALL remain present in both builds.

Structure
REQ-020 Package tone_synth_pkg SHALL hold the following:
- waveform-mode encodings (SAW=0, SQUARE=1, TRI=2, MUTE=3);
- the MIX_W calculation function;
- the NVOICE maximum constant (4).
REQ-021 One sub-module, tone_voice, SHALL hold the phase counter and waveform generation; it SHALL be instantiated NVOICE times.
- Mixing and the output register SHALL live in tone_synth.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Default params, saw, period=5, pan=3: 12 strobes -> audio_l samples 0,1,2,3,4,0,1,2,3,4,0,1 << 17; audio_r equals audio_l.
- NVOICE=2, both voices square, period=4: first 2 samples -> audio = 254 << 16; next 2 samples -> 0.
- Triangle, period=6: samples -> w = 0,2,4,4,2,0, repeating.
- Period lowered from 10 to 3 while ph=7 -> next sample emits 7, then ph wraps to 0.
- rst pulsed in the cycle after a new_sample -> sample_valid stays 0 and all ph restart from 0; also new_sample on two consecutive cycles -> two sample_valid pulses.
- TONE_SYNTH_PAN_EN, NVOICE=2, pan0=1, pan1=2 -> audio_l carries only voice 0 and audio_r only voice 1; same stimulus without the macro -> audio_l equals audio_r equals the sum.

Source files
------------

// File: rtl/tone_synth_pkg.sv
// Shared definitions for the tone synthesizer: waveform modes, voice limit
// and the mixer width helper.
package tone_synth_pkg;

  localparam int NVOICE_MAX = 4;

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_MUTE   = 2'd3
  } waveMode_e;

  // Enough headroom that summing every voice at full scale cannot wrap.
  function automatic int mixWidth(input int periodW, input int nVoice);
    return periodW + $clog2(nVoice);
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One synthesizer voice: a per-sample phase counter plus the waveform
// shaper that turns the current phase into an unsigned level.
module tone_voice
  import tone_synth_pkg::*;
#(
  parameter int PERIOD_W = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                newSample_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [1:0]          mode_i,
  output logic [PERIOD_W-1:0] wave_o
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] halfPeriod;
  logic [PERIOD_W-1:0] lastPhase;
  logic [PERIOD_W-1:0] fallSpan;
  logic [PERIOD_W:0]   twiceRise;
  logic [PERIOD_W:0]   twiceFall;
  logic                silent;
  waveMode_e           waveMode;

  assign silent     = (period_i == '0);
  assign waveMode   = waveMode_e'(mode_i);
  assign halfPeriod = period_i >> 1;
  assign lastPhase  = period_i - ONE;

  // >= rather than == so a period shortened below the current phase wraps
  // on the very next sample instead of running up to the counter limit.
  always_comb begin
    phase_d = phase_q;
    if (!enable_i || silent) begin
      phase_d = '0;
    end else if (newSample_i) begin
      phase_d = (phase_q >= lastPhase) ? '0 : phase_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // The falling edge is clamped at zero when the phase sits past a freshly
  // shortened period, so the triangle never wraps to a huge value.
  assign fallSpan  = (phase_q > lastPhase) ? '0 : lastPhase - phase_q;
  assign twiceRise = {phase_q, 1'b0};
  assign twiceFall = {fallSpan, 1'b0};

  always_comb begin
    wave_o = '0;
    if (!silent) begin
      case (waveMode)
        MODE_SAW:    wave_o = phase_q;
        MODE_SQUARE: wave_o = (phase_q < halfPeriod) ? '1 : '0;
        MODE_TRI: begin
          if (phase_q < halfPeriod) begin
            wave_o = twiceRise[PERIOD_W] ? '1 : twiceRise[PERIOD_W-1:0];
          end else begin
            wave_o = twiceFall[PERIOD_W] ? '1 : twiceFall[PERIOD_W-1:0];
          end
        end
        default:     wave_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Multi-voice tone synthesizer: NVOICE tone_voice instances mixed into a
// registered stereo sample. Define TONE_SYNTH_PAN_EN for per-voice panning.
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int NVOICE   = 1,
  parameter int PERIOD_W = 7,
  parameter int SAMPLE_W = 24
) (
  input  logic                         clk100,
  input  logic                         rst,
  input  logic                         new_sample,
  input  logic                         enable,
  input  logic [NVOICE*PERIOD_W-1:0]   period,
  input  logic [NVOICE*2-1:0]          mode,
  input  logic [NVOICE*2-1:0]          pan,
  output logic [SAMPLE_W-1:0]          audio_l,
  output logic [SAMPLE_W-1:0]          audio_r,
  output logic                         sample_valid
);

  localparam int MIX_W = mixWidth(PERIOD_W, NVOICE);
  localparam int SHIFT = SAMPLE_W - MIX_W;

  logic [NVOICE-1:0][PERIOD_W-1:0] wave;
  logic [MIX_W-1:0]                mixL, mixR;
  logic                            takeSample;
  logic [SAMPLE_W-1:0]             audioL_q, audioL_d;
  logic [SAMPLE_W-1:0]             audioR_q, audioR_d;
  logic                            sampleValid_q, sampleValid_d;

  assign takeSample = new_sample & enable;

  for (genvar v = 0; v < NVOICE; v++) begin : g_voice
    tone_voice #(
      .PERIOD_W (PERIOD_W)
    ) u_voice (
      .clk_i       (clk100),
      .rst_i       (rst),
      .enable_i    (enable),
      .newSample_i (new_sample),
      .period_i    (period[v*PERIOD_W +: PERIOD_W]),
      .mode_i      (mode[v*2 +: 2]),
      .wave_o      (wave[v])
    );
  end

`ifdef TONE_SYNTH_PAN_EN
  always_comb begin
    mixL = '0;
    mixR = '0;
    for (int v = 0; v < NVOICE; v++) begin
      if (pan[2*v])   mixL = mixL + MIX_W'(wave[v]);
      if (pan[2*v+1]) mixR = mixR + MIX_W'(wave[v]);
    end
  end
`else
  // Pan is kept on the port list so both builds share one interface.
  logic unusedPan;
  assign unusedPan = ^pan;

  always_comb begin
    mixL = '0;
    for (int v = 0; v < NVOICE; v++) begin
      mixL = mixL + MIX_W'(wave[v]);
    end
    mixR = mixL;
  end
`endif

  always_comb begin
    sampleValid_d = takeSample;
    audioL_d      = '0;
    audioR_d      = '0;
    if (takeSample) begin
      audioL_d = SAMPLE_W'(mixL) << SHIFT;
      audioR_d = SAMPLE_W'(mixR) << SHIFT;
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      audioL_q      <= '0;
      audioR_q      <= '0;
      sampleValid_q <= 1'b0;
    end else begin
      audioL_q      <= audioL_d;
      audioR_q      <= audioR_d;
      sampleValid_q <= sampleValid_d;
    end
  end

  // Masking with rst lets a reset raised right after a strobe drop the
  // pulse that is already sitting in the output register.
  assign sample_valid = sampleValid_q & ~rst;
  assign audio_l      = rst ? '0 : audioL_q;
  assign audio_r      = rst ? '0 : audioR_q;

endmodule

// File: tb/tb_tone_synth.sv
// Self-checking bench for tone_synth: a one-voice and a two-voice instance,
// table-driven strobes scored through per-instance expectation queues.
module tb_tone_synth;
  import tone_synth_pkg::*;

  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  logic        rst, enable;
  logic        newA, newB;
  logic [6:0]  periodA;
  logic [1:0]  modeA, panA;
  logic [23:0] audioLA, audioRA;
  logic        validA;
  logic [13:0] periodB;
  logic [3:0]  modeB, panB;
  logic [23:0] audioLB, audioRB;
  logic        validB;

  int checks = 0;
  int errors = 0;
  bit monOn  = 1'b0;

  typedef struct {
    bit          useB;
    bit          clearFirst;
    logic [13:0] period;
    logic [3:0]  mode;
    logic [3:0]  pan;
    logic [23:0] expL;
    logic [23:0] expR;
  } vec_t;

  vec_t        vecs[$];
  logic [47:0] qA[$];
  logic [47:0] qB[$];
  logic [47:0] eA, eB;
  int          triSeq[6] = '{0, 2, 4, 4, 2, 0};
  int          lowSeq[5] = '{7, 0, 1, 2, 0};

  tone_synth dutA (
    .clk100       (clk100),
    .rst          (rst),
    .new_sample   (newA),
    .enable       (enable),
    .period       (periodA),
    .mode         (modeA),
    .pan          (panA),
    .audio_l      (audioLA),
    .audio_r      (audioRA),
    .sample_valid (validA)
  );

  tone_synth #(
    .NVOICE (2)
  ) dutB (
    .clk100       (clk100),
    .rst          (rst),
    .new_sample   (newB),
    .enable       (enable),
    .period       (periodB),
    .mode         (modeB),
    .pan          (panB),
    .audio_l      (audioLB),
    .audio_r      (audioRB),
    .sample_valid (validB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input bit useB, input bit clr, input logic [13:0] p,
                                 input logic [3:0] m, input logic [3:0] pn,
                                 input logic [23:0] l, input logic [23:0] r);
    vec_t v;
    v.useB = useB; v.clearFirst = clr; v.period = p; v.mode = m; v.pan = pn;
    v.expL = l; v.expR = r;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    if (v.clearFirst) begin
      enable = 1'b0;
      @(posedge clk100); #1;
      enable = 1'b1;
    end
    if (!v.useB) begin
      periodA = v.period[6:0]; modeA = v.mode[1:0]; panA = v.pan[1:0];
      newA = 1'b1;
      qA.push_back({v.expL, v.expR});
    end else begin
      periodB = v.period; modeB = v.mode; panB = v.pan;
      newB = 1'b1;
      qB.push_back({v.expL, v.expR});
    end
    @(posedge clk100); #1;
    newA = 1'b0;
    newB = 1'b0;
    @(posedge clk100); #1;
  endtask

  always @(negedge clk100) begin
    if (monOn) begin
      if (validA) begin
        if (qA.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpectedValidA actual=1 expected=0");
        end else begin
          eA = qA.pop_front();
          checkOutput("audioLA", 32'(audioLA), 32'(eA[47:24]));
          checkOutput("audioRA", 32'(audioRA), 32'(eA[23:0]));
        end
      end else begin
        checkOutput("idleA", 32'(audioLA | audioRA), 32'd0);
      end
    end
  end

  always @(negedge clk100) begin
    if (monOn) begin
      if (validB) begin
        if (qB.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpectedValidB actual=1 expected=0");
        end else begin
          eB = qB.pop_front();
          checkOutput("audioLB", 32'(audioLB), 32'(eB[47:24]));
          checkOutput("audioRB", 32'(audioRB), 32'(eB[23:0]));
        end
      end else begin
        checkOutput("idleB", 32'(audioLB | audioRB), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0, p1;
    rst = 1'b1; enable = 1'b0; newA = 1'b0; newB = 1'b0;
    periodA = '0; modeA = '0; panA = '0;
    periodB = '0; modeB = '0; panB = '0;

    // Saw, period 5, single voice: 0..4 repeating, shifted by 24-7.
    for (int i = 0; i < 12; i++)
      vecs.push_back(mkVec(0, i == 0, 14'd5, 4'd0, 4'd3,
                           24'(i % 5) << 17, 24'(i % 5) << 17));
    // Triangle, period 6.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mkVec(0, i == 0, 14'd6, 4'd2, 4'd3,
                           24'(triSeq[i % 6]) << 17, 24'(triSeq[i % 6]) << 17));
    // Saw at period 10 up to ph=7, then period lowered to 3.
    for (int i = 0; i < 7; i++)
      vecs.push_back(mkVec(0, i == 0, 14'd10, 4'd0, 4'd3, 24'(i) << 17, 24'(i) << 17));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkVec(0, 0, 14'd3, 4'd0, 4'd3,
                           24'(lowSeq[i]) << 17, 24'(lowSeq[i]) << 17));
    // Two voices, both square, period 4: full scale 254 then silence.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mkVec(1, i == 0, {7'd4, 7'd4}, 4'b0101, 4'b1111,
                           24'(i < 2 ? 254 : 0) << 16, 24'(i < 2 ? 254 : 0) << 16));
    // Voice 0 saw period 5 panned left, voice 1 saw period 3 panned right.
    for (int i = 0; i < 6; i++) begin
      p0 = i % 5;
      p1 = i % 3;
`ifdef TONE_SYNTH_PAN_EN
      vecs.push_back(mkVec(1, i == 0, {7'd3, 7'd5}, 4'b0000, 4'b1001,
                           24'(p0) << 16, 24'(p1) << 16));
`else
      vecs.push_back(mkVec(1, i == 0, {7'd3, 7'd5}, 4'b0000, 4'b1001,
                           24'(p0 + p1) << 16, 24'(p0 + p1) << 16));
`endif
    end

    repeat (3) @(posedge clk100);
    #1 rst = 1'b0;
    @(negedge clk100);
    checkOutput("resetValidA", 32'(validA), 32'd0);
    checkOutput("resetAudioA", 32'(audioLA | audioRA), 32'd0);
    checkOutput("resetValidB", 32'(validB), 32'd0);
    checkOutput("resetAudioB", 32'(audioLB | audioRB), 32'd0);
    @(posedge clk100); #1;
    enable = 1'b1;
    monOn  = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Reset raised the cycle after a strobe: pulse dropped, phase restarts.
    applyStimulus(mkVec(0, 1, 14'd5, 4'd0, 4'd3, 24'd0, 24'd0));
    applyStimulus(mkVec(0, 0, 14'd5, 4'd0, 4'd3, 24'd1 << 17, 24'd1 << 17));
    newA = 1'b1;
    @(posedge clk100); #1;
    newA = 1'b0;
    rst  = 1'b1;
    @(negedge clk100);
    checkOutput("rstDropValid", 32'(validA), 32'd0);
    @(posedge clk100); #1;
    rst = 1'b0;
    applyStimulus(mkVec(0, 0, 14'd5, 4'd0, 4'd3, 24'd0, 24'd0));
    applyStimulus(mkVec(0, 0, 14'd5, 4'd0, 4'd3, 24'd1 << 17, 24'd1 << 17));

    // Back-to-back strobes must each yield a sample.
    newA = 1'b1;
    qA.push_back({24'd2 << 17, 24'd2 << 17});
    @(posedge clk100); #1;
    qA.push_back({24'd3 << 17, 24'd3 << 17});
    @(posedge clk100); #1;
    newA = 1'b0;
    repeat (2) @(posedge clk100); #1;

    // Enable drop: the pulse already registered still appears, the strobe
    // seen while disabled is ignored, and the phase comes back at 0.
    newA = 1'b1;
    qA.push_back({24'd4 << 17, 24'd4 << 17});
    @(posedge clk100); #1;
    enable = 1'b0;
    @(posedge clk100); #1;
    enable = 1'b1;
    newA   = 1'b0;
    @(posedge clk100); #1;
    applyStimulus(mkVec(0, 0, 14'd5, 4'd0, 4'd3, 24'd0, 24'd0));

    for (int k = 0; k < 20 && (qA.size() != 0 || qB.size() != 0); k++)
      @(posedge clk100);
    @(negedge clk100);
    checkOutput("drainA", 32'(qA.size()), 32'd0);
    checkOutput("drainB", 32'(qB.size()), 32'd0);
    monOn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
